// File: rtl/mesi_snoop_cache.sv
// Direct-mapped MESI snooping cache controller: one processor request port,
// one shared-bus port (arbitration, commands, fill) and a snoop responder.
module mesi_snoop_cache #(
  parameter int IDX_W  = 2,
  parameter int TAG_W  = 3,
  parameter int DATA_W = 3
) (
  input  logic                   clock,
  input  logic                   clear,
  input  logic                   cpu_req,
  input  logic                   cpu_we,
  input  logic [TAG_W+IDX_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0]      cpu_wdata,
  output logic                   cpu_busy,
  output logic                   cpu_done,
  output logic [DATA_W-1:0]      cpu_rdata,
  output logic                   cpu_hit,
  output logic                   bus_req,
  input  logic                   bus_gnt,
  output logic                   bus_valid,
  output logic [2:0]             bus_cmd,
  output logic [TAG_W+IDX_W-1:0] bus_addr,
  output logic [DATA_W-1:0]      bus_wdata,
  input  logic                   mem_valid,
  input  logic [DATA_W-1:0]      mem_rdata,
  input  logic                   shared_in,
  input  logic                   snp_valid,
  input  logic [2:0]             snp_cmd,
  input  logic [TAG_W+IDX_W-1:0] snp_addr,
  output logic                   shared_out,
  output logic                   flush_valid,
  output logic [DATA_W-1:0]      flush_data
);
  localparam int unsigned LINES = 1 << IDX_W;
  localparam int ADDR_W = TAG_W + IDX_W;

  typedef enum logic [1:0] {ST_I = 2'b00, ST_S = 2'b01, ST_E = 2'b10, ST_M = 2'b11} mesi_t;
  typedef enum logic [2:0] {
    CMD_NONE = 3'd0, CMD_RD = 3'd1, CMD_RDX = 3'd2, CMD_UPGR = 3'd3, CMD_FLUSH = 3'd4
  } cmd_t;
  typedef enum logic [2:0] {
    IDLE, LOOKUP, WB_REQ, WB_CMD, BUS_REQ, BUS_CMD, WAIT_FILL, DONE
  } fsm_t;

  mesi_t             st [LINES];
  logic [TAG_W-1:0]  tg [LINES];
  logic [DATA_W-1:0] dt [LINES];

  fsm_t              state, next;
  logic              r_we;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_wdata;
  cmd_t              r_cmd;
  logic              wb_gap;

  logic [IDX_W-1:0]  idx, s_idx;
  logic [TAG_W-1:0]  rtag;
  logic              lhit, upgr, collide;
  logic              s_hit, s_flush, s_mod;
  mesi_t             s_next;

  assign idx     = r_addr[IDX_W-1:0];
  assign rtag    = r_addr[ADDR_W-1:IDX_W];
  assign lhit    = (st[idx] != ST_I) && (tg[idx] == rtag);
  assign upgr    = lhit && r_we && (st[idx] == ST_S);
  assign s_idx   = snp_addr[IDX_W-1:0];
  assign s_hit   = snp_valid && (st[s_idx] != ST_I) && (tg[s_idx] == snp_addr[ADDR_W-1:IDX_W]);
  assign collide = s_mod && (s_idx == idx);

  always_comb begin
    s_next  = st[s_idx];
    s_flush = 1'b0;
    if (s_hit) begin
      case (snp_cmd)
        CMD_RD: begin
          s_flush = (st[s_idx] == ST_M);
          s_next  = ST_S;
        end
        CMD_RDX: begin
          s_flush = (st[s_idx] == ST_M);
          s_next  = ST_I;
        end
        CMD_UPGR: if (st[s_idx] == ST_S) s_next = ST_I;
        default: ;
      endcase
    end
    s_mod = s_hit && (s_next != st[s_idx]);
  end

  always_ff @(posedge clock) begin
    if (clear) state <= IDLE;
    else       state <= next;
  end

  always_comb begin
    next      = state;
    cpu_busy  = (state != IDLE);
    cpu_done  = 1'b0;
    bus_req   = 1'b0;
    bus_valid = 1'b0;
    bus_cmd   = '0;
    bus_addr  = '0;
    bus_wdata = '0;
    case (state)
      IDLE: if (cpu_req) next = LOOKUP;
      LOOKUP: begin
        // A snoop changing this line in the same cycle wins; re-evaluate next cycle.
        if (!collide) begin
          if (lhit && !upgr)        next = DONE;
          else if (lhit)            next = BUS_REQ;
          else if (st[idx] == ST_M) next = WB_REQ;
          else                      next = BUS_REQ;
        end
      end
      WB_REQ: begin
        bus_req = 1'b1;
        if (st[idx] != ST_M) next = BUS_REQ;
        else if (bus_gnt)    next = WB_CMD;
      end
      WB_CMD: begin
        bus_req   = 1'b1;
        bus_valid = 1'b1;
        bus_cmd   = CMD_FLUSH;
        bus_addr  = {tg[idx], idx};
        bus_wdata = dt[idx];
        next      = BUS_REQ;
      end
      BUS_REQ: begin
        // After a write-back the request is withdrawn for one cycle before re-arbitrating.
        bus_req = !wb_gap;
        if (bus_gnt && !wb_gap) next = BUS_CMD;
      end
      BUS_CMD: begin
        bus_req   = 1'b1;
        bus_valid = 1'b1;
        bus_cmd   = r_cmd;
        bus_addr  = r_addr;
        next      = (r_cmd == CMD_UPGR) ? DONE : WAIT_FILL;
      end
      WAIT_FILL: begin
        bus_req = 1'b1;
        if (mem_valid) next = DONE;
      end
      DONE: begin
        cpu_done = 1'b1;
        next     = IDLE;
      end
      default: next = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (clear) begin
      for (int unsigned i = 0; i < LINES; i++) begin
        st[i] <= ST_I;
        tg[i] <= '0;
        dt[i] <= '0;
      end
      r_we        <= 1'b0;
      r_addr      <= '0;
      r_wdata     <= '0;
      r_cmd       <= CMD_NONE;
      wb_gap      <= 1'b0;
      cpu_rdata   <= '0;
      cpu_hit     <= 1'b0;
      shared_out  <= 1'b0;
      flush_valid <= 1'b0;
      flush_data  <= '0;
    end else begin
      case (state)
        IDLE: if (cpu_req) begin
          r_we    <= cpu_we;
          r_addr  <= cpu_addr;
          r_wdata <= cpu_wdata;
        end
        LOOKUP: if (!collide) begin
          r_cmd <= upgr ? CMD_UPGR : (r_we ? CMD_RDX : CMD_RD);
          if (lhit && !upgr) begin
            cpu_hit   <= 1'b1;
            cpu_rdata <= r_we ? r_wdata : dt[idx];
            if (r_we) begin
              st[idx] <= ST_M;
              dt[idx] <= r_wdata;
            end
          end
        end
        WB_CMD: begin
          st[idx] <= ST_I;
          wb_gap  <= 1'b1;
        end
        BUS_REQ: wb_gap <= 1'b0;
        BUS_CMD: if (r_cmd == CMD_UPGR) begin
          st[idx]   <= ST_M;
          tg[idx]   <= rtag;
          dt[idx]   <= r_wdata;
          cpu_hit   <= 1'b0;
          cpu_rdata <= r_wdata;
        end
        WAIT_FILL: if (mem_valid) begin
          tg[idx] <= rtag;
          cpu_hit <= 1'b0;
          if (r_we) begin
            st[idx]   <= ST_M;
            dt[idx]   <= r_wdata;
            cpu_rdata <= r_wdata;
          end else begin
            st[idx]   <= shared_in ? ST_S : ST_E;
            dt[idx]   <= mem_rdata;
            cpu_rdata <= mem_rdata;
          end
        end
        default: ;
      endcase
      // Snoop updates come last so they override a same-cycle FSM write.
      shared_out  <= s_hit;
      flush_valid <= s_flush;
      if (s_flush) flush_data <= dt[s_idx];
      if (s_mod)   st[s_idx]  <= s_next;
    end
  end
endmodule

// File: tb/tb_mesi_snoop_cache.sv
// Randomized self-checking bench for mesi_snoop_cache against a transaction-level
// MESI model; the bench also plays arbiter, memory and other snooping nodes.
module tb_mesi_snoop_cache;
  localparam logic [2:0] C_RD = 3'd1, C_RDX = 3'd2, C_UPGR = 3'd3, C_FLUSH = 3'd4;
  localparam logic [1:0] MI = 2'd0, MS = 2'd1, ME = 2'd2, MM = 2'd3;

  logic       clock, clear;
  logic       cpu_req, cpu_we;
  logic [4:0] cpu_addr;
  logic [2:0] cpu_wdata;
  logic       cpu_busy, cpu_done, cpu_hit;
  logic [2:0] cpu_rdata;
  logic       bus_req, bus_gnt, bus_valid;
  logic [2:0] bus_cmd;
  logic [4:0] bus_addr;
  logic [2:0] bus_wdata;
  logic       mem_valid, shared_in;
  logic [2:0] mem_rdata;
  logic       snp_valid;
  logic [2:0] snp_cmd;
  logic [4:0] snp_addr;
  logic       shared_out, flush_valid;
  logic [2:0] flush_data;

  mesi_snoop_cache #(.IDX_W(2), .TAG_W(3), .DATA_W(3)) dut (
    .clock(clock), .clear(clear),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_busy(cpu_busy), .cpu_done(cpu_done), .cpu_rdata(cpu_rdata), .cpu_hit(cpu_hit),
    .bus_req(bus_req), .bus_gnt(bus_gnt), .bus_valid(bus_valid), .bus_cmd(bus_cmd),
    .bus_addr(bus_addr), .bus_wdata(bus_wdata),
    .mem_valid(mem_valid), .mem_rdata(mem_rdata), .shared_in(shared_in),
    .snp_valid(snp_valid), .snp_cmd(snp_cmd), .snp_addr(snp_addr),
    .shared_out(shared_out), .flush_valid(flush_valid), .flush_data(flush_data)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int n_chk = 0;
  int n_pass = 0;

  logic [1:0] m_st [4];
  logic [2:0] m_tg [4];
  logic [2:0] m_dt [4];
  logic [2:0] q_cmd [$];
  logic [4:0] q_addr [$];
  logic [2:0] q_data [$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    else n_pass++;
  endtask

  task automatic model_reset();
    for (int i = 0; i < 4; i++) begin
      m_st[i] = MI; m_tg[i] = '0; m_dt[i] = '0;
    end
    q_cmd.delete(); q_addr.delete(); q_data.delete();
  endtask

  // Another node's command against our copy of the line.
  task automatic apply_snoop(input logic [2:0] c, input logic [4:0] a,
                             output logic sh, output logic fl, output logic [2:0] fd);
    logic [1:0] i;
    i  = a[1:0];
    sh = (m_st[i] != MI) && (m_tg[i] == a[4:2]);
    fl = 1'b0;
    fd = m_dt[i];
    if (sh) begin
      if (c == C_RD) begin
        fl = (m_st[i] == MM);
        if (m_st[i] != MS) m_st[i] = MS;
      end else if (c == C_RDX) begin
        fl = (m_st[i] == MM);
        m_st[i] = MI;
      end else if (c == C_UPGR && m_st[i] == MS) begin
        m_st[i] = MI;
      end
    end
  endtask

  // Expected bus traffic and completion values for one processor request.
  task automatic plan_req(input logic we, input logic [4:0] a, input logic [2:0] wd,
                          input logic [2:0] fill, input logic sh,
                          output logic hit, output logic [2:0] rd);
    logic [1:0] i;
    i   = a[1:0];
    hit = (m_st[i] != MI) && (m_tg[i] == a[4:2]);
    rd  = m_dt[i];
    if (hit && we && m_st[i] == MS) begin
      hit = 1'b0;
      q_cmd.push_back(C_UPGR); q_addr.push_back(a); q_data.push_back(3'd0);
      m_st[i] = MM; m_dt[i] = wd;
    end else if (hit) begin
      if (we) begin m_st[i] = MM; m_dt[i] = wd; end
    end else begin
      if (m_st[i] == MM) begin
        q_cmd.push_back(C_FLUSH); q_addr.push_back({m_tg[i], i}); q_data.push_back(m_dt[i]);
      end
      q_cmd.push_back(we ? C_RDX : C_RD); q_addr.push_back(a); q_data.push_back(3'd0);
      m_tg[i] = a[4:2];
      if (we) begin m_st[i] = MM; m_dt[i] = wd; end
      else begin m_st[i] = sh ? MS : ME; m_dt[i] = fill; rd = fill; end
    end
  endtask

  task automatic do_snoop(input logic [2:0] c, input logic [4:0] a);
    logic esh, efl;
    logic [2:0] efd;
    apply_snoop(c, a, esh, efl, efd);
    @(negedge clock);
    snp_valid = 1'b1; snp_cmd = c; snp_addr = a;
    @(negedge clock);
    snp_valid = 1'b0;
    check("snp_shared", shared_out, esh);
    check("snp_flush", flush_valid, efl);
    if (efl) check("snp_fdata", flush_data, efd);
    @(negedge clock);
    check("snp_shared_off", shared_out, 0);
    check("snp_flush_off", flush_valid, 0);
  endtask

  task automatic do_req(input logic we, input logic [4:0] a, input logic [2:0] wd,
                        input logic [2:0] fill, input logic sh,
                        input logic inj, input logic [2:0] icmd, input logic [4:0] iaddr);
    logic esh, efl, ehit, done, owned, saw_req, gap_chk;
    logic [2:0] efd, erd, ec, ed;
    logic [4:0] ea;
    int n, gw, fc;
    esh = 1'b0; efl = 1'b0; efd = '0;
    if (inj) apply_snoop(icmd, iaddr, esh, efl, efd);
    plan_req(we, a, wd, fill, sh, ehit, erd);
    @(negedge clock);
    cpu_req = 1'b1; cpu_we = we; cpu_addr = a; cpu_wdata = wd;
    @(negedge clock);
    cpu_req = 1'b0;
    check("busy", cpu_busy, 1);
    if (inj) begin snp_valid = 1'b1; snp_cmd = icmd; snp_addr = iaddr; end
    n = 0; gw = $urandom_range(0, 2); fc = -1;
    done = 1'b0; owned = 1'b0; saw_req = 1'b0; gap_chk = 1'b0;
    while (!done && n < 80) begin
      @(negedge clock);
      n++;
      mem_valid = 1'b0;
      if (n == 1 && inj) begin
        snp_valid = 1'b0;
        check("lk_snp_shared", shared_out, esh);
        check("lk_snp_flush", flush_valid, efl);
        if (efl) check("lk_snp_fdata", flush_data, efd);
      end
      if (gap_chk) begin check("wb_gap", bus_req, 0); gap_chk = 1'b0; end
      if (bus_req) saw_req = 1'b1;
      if (fc > 0) begin
        fc--;
        if (fc == 0) begin mem_valid = 1'b1; mem_rdata = fill; shared_in = sh; end
      end
      if (cpu_done) begin
        done = 1'b1;
        check("hit", cpu_hit, ehit);
        if (!we) check("rdata", cpu_rdata, erd);
        check("bus_left", q_cmd.size(), 0);
        if (ehit) begin
          check("hit_nobus", saw_req, 0);
          if (!inj) check("hit_latency", n, 1);
        end
      end
      if (bus_valid) begin
        bus_gnt = 1'b0;
        gw = $urandom_range(0, 2);
        if (q_cmd.size() == 0) check("bus_cmd_extra", bus_cmd, 0);
        else begin
          ec = q_cmd.pop_front(); ea = q_addr.pop_front(); ed = q_data.pop_front();
          check("bus_cmd", bus_cmd, ec);
          check("bus_addr", bus_addr, ea);
          if (ec == C_FLUSH) begin check("bus_wdata", bus_wdata, ed); gap_chk = 1'b1; end
          if (ec == C_RD || ec == C_RDX) begin owned = 1'b1; fc = $urandom_range(1, 3); end
        end
      end else if (bus_req && !owned && !bus_gnt) begin
        if (gw == 0) bus_gnt = 1'b1;
        else gw--;
      end
    end
    if (!done) check("done_timeout", 0, 1);
    mem_valid = 1'b0; bus_gnt = 1'b0;
    q_cmd.delete(); q_addr.delete(); q_data.delete();
    @(negedge clock);
    check("idle_busy", cpu_busy, 0);
  endtask

  task automatic clr_mid();
    logic [2:0] t;
    logic got;
    int n;
    t = m_tg[1] + 3'd1;
    @(negedge clock);
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = {t, 2'b01}; cpu_wdata = '0;
    @(negedge clock);
    cpu_req = 1'b0;
    got = 1'b0; n = 0;
    while (!got && n < 40) begin
      @(negedge clock);
      n++;
      if (bus_valid) begin
        bus_gnt = 1'b0;
        if (bus_cmd == C_RD) got = 1'b1;
      end else if (bus_req && !bus_gnt) bus_gnt = 1'b1;
    end
    check("clr_busrd_seen", got, 1);
    @(negedge clock);
    clear = 1'b1;
    @(negedge clock);
    clear = 1'b0;
    check("clr_bus_req", bus_req, 0);
    check("clr_busy", cpu_busy, 0);
    check("clr_done", cpu_done, 0);
    mem_valid = 1'b1; mem_rdata = 3'b111; shared_in = 1'b0;
    @(negedge clock);
    mem_valid = 1'b0;
    check("clr_late_fill_done", cpu_done, 0);
    check("clr_late_fill_busy", cpu_busy, 0);
    model_reset();
  endtask

  function automatic logic [4:0] pick_addr();
    logic [1:0] i;
    logic [2:0] t;
    i = 2'($urandom_range(0, 3));
    t = 3'($urandom_range(0, 2));
    if ($urandom_range(0, 1) == 1 && m_st[i] != MI) t = m_tg[i];
    return {t, i};
  endfunction

  initial begin
    logic [4:0] a;
    clear = 1'b1; cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0;
    bus_gnt = 1'b0; mem_valid = 1'b0; mem_rdata = '0; shared_in = 1'b0;
    snp_valid = 1'b0; snp_cmd = '0; snp_addr = '0;
    model_reset();
    repeat (3) @(negedge clock);
    check("rst_busy", cpu_busy, 0);
    check("rst_done", cpu_done, 0);
    check("rst_bus_req", bus_req, 0);
    check("rst_bus_valid", bus_valid, 0);
    check("rst_shared", shared_out, 0);
    check("rst_flush", flush_valid, 0);
    check("rst_rdata", cpu_rdata, 0);
    clear = 1'b0;

    do_req(1'b0, 5'b101_01, 3'b000, 3'b110, 1'b0, 1'b0, 3'd0, 5'd0);
    do_req(1'b0, 5'b101_01, 3'b000, 3'b000, 1'b0, 1'b0, 3'd0, 5'd0);
    do_req(1'b1, 5'b101_01, 3'b011, 3'b000, 1'b0, 1'b0, 3'd0, 5'd0);
    do_snoop(C_RD, 5'b101_01);
    do_req(1'b0, 5'b011_10, 3'b000, 3'b010, 1'b1, 1'b0, 3'd0, 5'd0);
    do_req(1'b1, 5'b011_10, 3'b101, 3'b000, 1'b0, 1'b0, 3'd0, 5'd0);
    do_req(1'b1, 5'b101_01, 3'b011, 3'b000, 1'b0, 1'b0, 3'd0, 5'd0);
    do_req(1'b0, 5'b010_01, 3'b000, 3'b100, 1'b0, 1'b0, 3'd0, 5'd0);
    do_req(1'b1, 5'b010_01, 3'b001, 3'b000, 1'b0, 1'b1, C_RDX, 5'b010_01);
    clr_mid();
    do_req(1'b0, 5'b010_01, 3'b000, 3'b101, 1'b1, 1'b0, 3'd0, 5'd0);

    for (int k = 0; k < 150; k++) begin
      if ($urandom_range(0, 3) == 0) do_snoop(3'($urandom_range(1, 4)), pick_addr());
      a = pick_addr();
      do_req(1'($urandom_range(0, 1)), a, 3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)),
             1'($urandom_range(0, 1)), ($urandom_range(0, 3) == 0),
             3'($urandom_range(1, 4)), pick_addr());
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, %0d/%0d so far", n_pass, n_chk);
    $fatal(1);
  end
endmodule
